// File: rtl/gpa_fhdo_pkg.sv
// gpa_fhdo_pkg: shared types, word layout and word assembly for the gpa_fhdo sequencer
package gpa_fhdo_pkg;

    localparam int GPA_NCH  = 4;
    localparam int CH_LSB   = 25;
    localparam int CH_W     = 2;
    localparam int LOAD_BIT = 24;
    localparam int PAY_W    = 24;
    localparam int CODE_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_WAIT_DONE,
        ST_NEXT
    } state_t;

    function automatic logic [31:0] mk_word(input logic [CH_W-1:0] ch, input logic load,
                                            input logic [PAY_W-1:0] payload);
        logic [31:0] w;
        w = '0;
        w[CH_LSB +: CH_W] = ch;
        w[LOAD_BIT] = load;
        w[PAY_W-1:0] = payload;
        return w;
    endfunction

endpackage

// File: rtl/gpa_fhdo_seq.sv
// gpa_fhdo_seq: paces gradient updates and raw config frames into gpa_fhdo_iface word by word
module gpa_fhdo_seq
    import gpa_fhdo_pkg::*;
#(
    parameter int          ACK_TIMEOUT  = 256,
    parameter logic [7:0]  DAC_REG_BASE = 8'h08
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [63:0] grad_i,
    input  logic        grad_valid_i,
    output logic        grad_ready_o,
    input  logic [23:0] cfg_i,
    input  logic        cfg_valid_i,
    output logic        cfg_ready_o,
    output logic [31:0] data_o,
    output logic        valid_o,
    input  logic        busy_i,
    output logic        seq_busy_o,
    output logic [31:0] upd_count_o,
    output logic        err_o,
    input  logic        err_clr_i
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    state_t          state, state_n;
    logic [63:0]     grad_q;
    logic            is_cfg;
    logic [1:0]      idx, idx_n;
    logic [TW-1:0]   timer;
    logic            cfg_acc, grad_acc, abort, last, load_word;
    logic [63:0]     grad_src;
    logic [31:0]     word_n;

    assign valid_o    = state == ST_ISSUE;
    assign seq_busy_o = state != ST_IDLE;

    // Handshakes, the word for the next ISSUE, and next-state selection
    always_comb begin
        cfg_ready_o  = rstn && state == ST_IDLE && !busy_i;
        grad_ready_o = cfg_ready_o && !cfg_valid_i;
        cfg_acc      = cfg_valid_i && cfg_ready_o;
        grad_acc     = grad_valid_i && grad_ready_o;
        last         = is_cfg || idx == 2'(GPA_NCH - 1);
        abort        = state == ST_WAIT_ACK && !busy_i && timer == TW'(ACK_TIMEOUT - 1);
        idx_n        = state == ST_IDLE ? 2'd0 : idx + 2'd1;
        grad_src     = state == ST_IDLE ? grad_i : grad_q;
        word_n       = cfg_acc ? mk_word(2'd0, 1'b0, cfg_i)
                               : mk_word(idx_n, idx_n == 2'(GPA_NCH - 1),
                                         {DAC_REG_BASE + {6'd0, idx_n}, grad_src[{idx_n, 4'b0} +: CODE_W]});
        load_word    = (state == ST_IDLE && (cfg_acc || grad_acc)) || (state == ST_NEXT && !last);
        state_n      = state;
        case (state)
            ST_IDLE:      state_n = (cfg_acc || grad_acc) ? ST_ISSUE : ST_IDLE;
            ST_ISSUE:     state_n = ST_WAIT_ACK;
            ST_WAIT_ACK:  state_n = busy_i ? ST_WAIT_DONE : abort ? ST_IDLE : ST_WAIT_ACK;
            ST_WAIT_DONE: state_n = busy_i ? ST_WAIT_DONE : ST_NEXT;
            ST_NEXT:      state_n = last ? ST_IDLE : ST_ISSUE;
            default:      state_n = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_n;
    end

    // Operand latches, channel index and the held output word
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            grad_q <= '0;
            is_cfg <= 1'b0;
            idx    <= '0;
            data_o <= '0;
        end else begin
            if (grad_acc) grad_q <= grad_i;
            if (state == ST_IDLE && (cfg_acc || grad_acc)) is_cfg <= cfg_acc;
            if (load_word) begin
                idx    <= idx_n;
                data_o <= word_n;
            end
        end
    end

    // Ack timer: cleared on each strobe, counts while the interface has not yet gone busy
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                               timer <= '0;
        else if (state == ST_ISSUE)              timer <= '0;
        else if (state == ST_WAIT_ACK && !busy_i) timer <= timer + 1'b1;
    end

    // Completed-update counter and sticky timeout error (clear wins over set)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            upd_count_o <= '0;
            err_o       <= 1'b0;
        end else begin
            if (state == ST_NEXT && !is_cfg && last) upd_count_o <= upd_count_o + 32'd1;
            err_o <= err_clr_i ? 1'b0 : abort ? 1'b1 : err_o;
        end
    end

endmodule

// File: tb/tb_gpa_fhdo_seq.sv
// tb_gpa_fhdo_seq: scoreboard bench for the gpa_fhdo sequencer with a simple interface busy model
module tb_gpa_fhdo_seq;

    localparam int ACK_TIMEOUT = 256;
    localparam int BUSY_LEN    = 40;
    localparam int BOUND       = 3000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [63:0] grad_i = '0;
    logic        grad_valid_i = 1'b0;
    logic        grad_ready_o;
    logic [23:0] cfg_i = '0;
    logic        cfg_valid_i = 1'b0;
    logic        cfg_ready_o;
    logic [31:0] data_o;
    logic        valid_o;
    logic        busy_i = 1'b0;
    logic        seq_busy_o;
    logic [31:0] upd_count_o;
    logic        err_o;
    logic        err_clr_i = 1'b0;

    logic [31:0] exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_strobe = 0;
    int          n_load = 0;
    logic        busy_en = 1'b1;
    logic [31:0] exp_cnt = 0;

    gpa_fhdo_seq #(.ACK_TIMEOUT(ACK_TIMEOUT), .DAC_REG_BASE(8'h08)) dut (
        .clk(clk), .rstn(rstn), .grad_i(grad_i), .grad_valid_i(grad_valid_i),
        .grad_ready_o(grad_ready_o), .cfg_i(cfg_i), .cfg_valid_i(cfg_valid_i),
        .cfg_ready_o(cfg_ready_o), .data_o(data_o), .valid_o(valid_o), .busy_i(busy_i),
        .seq_busy_o(seq_busy_o), .upd_count_o(upd_count_o), .err_o(err_o), .err_clr_i(err_clr_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] gword(input int ch, input logic [15:0] code);
        return (32'(ch) << 25) | ((ch == 3) ? 32'h0100_0000 : 32'h0) | ((32'h8 + 32'(ch)) << 16) | 32'(code);
    endfunction

    // Interface model: goes busy one cycle after a strobe and stays busy BUSY_LEN cycles
    initial forever begin
        @(negedge clk);
        if (valid_o && busy_en) begin
            @(negedge clk);
            busy_i = 1'b1;
            repeat (BUSY_LEN) @(negedge clk);
            busy_i = 1'b0;
        end
    end

    // Output monitor: every strobe is compared with the head of the scoreboard
    initial forever begin
        @(negedge clk);
        if (valid_o) begin
            n_strobe++;
            if (data_o[24]) n_load++;
            if (exp_q.size() == 0) check("unexpected_word", data_o, 32'hxxxx_xxxx);
            else check("word", data_o, exp_q.pop_front());
        end
    end

    task automatic send_grad(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                             input logic [15:0] z2);
        int n;
        grad_i = {z2, z, y, x};
        grad_valid_i = 1'b1;
        n = 0;
        #1;
        while (!grad_ready_o && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (!grad_ready_o) begin
            check("grad_accept_timeout", 32'(grad_ready_o), 32'd1);
            grad_valid_i = 1'b0;
            return;
        end
        exp_q.push_back(gword(0, x));
        exp_q.push_back(gword(1, y));
        exp_q.push_back(gword(2, z));
        exp_q.push_back(gword(3, z2));
        @(negedge clk);
        grad_valid_i = 1'b0;
        check("grad_latency", 32'(valid_o), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((seq_busy_o || busy_i) && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(seq_busy_o || busy_i), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int n, base, loads;
        #12;
        check("rst_data", data_o, 0);
        check("rst_valid", 32'(valid_o), 0);
        check("rst_busy", 32'(seq_busy_o), 0);
        check("rst_cnt", upd_count_o, 0);
        check("rst_err", 32'(err_o), 0);
        check("rst_ready", 32'({cfg_ready_o, grad_ready_o}), 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        send_grad(16'd1, 16'd2, 16'd3, 16'd4);
        wait_idle();
        exp_cnt++;
        check("t1_cnt", upd_count_o, exp_cnt);

        cfg_i = 24'h030A00;
        cfg_valid_i = 1'b1;
        grad_i = {16'h0040, 16'h0030, 16'h0020, 16'h0010};
        grad_valid_i = 1'b1;
        #1;
        check("t2_cfg_ready", 32'(cfg_ready_o), 1);
        check("t2_grad_ready", 32'(grad_ready_o), 0);
        exp_q.push_back(32'h0003_0A00);
        @(negedge clk);
        cfg_valid_i = 1'b0;
        check("t2_cfg_latency", 32'(valid_o), 1);
        send_grad(16'h0010, 16'h0020, 16'h0030, 16'h0040);
        wait_idle();
        exp_cnt++;
        check("t2_cnt", upd_count_o, exp_cnt);

        busy_en = 1'b0;
        send_grad(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD);
        n = 0;
        while (!err_o && n < ACK_TIMEOUT + 20) begin
            @(negedge clk);
            n++;
        end
        check("t3_err", 32'(err_o), 1);
        check("t3_timeout_window", 32'(n >= ACK_TIMEOUT && n <= ACK_TIMEOUT + 2), 1);
        check("t3_idle", 32'(seq_busy_o), 0);
        check("t3_cnt", upd_count_o, exp_cnt);
        check("t3_dropped", exp_q.size(), 3);
        exp_q.delete();
        busy_en = 1'b1;
        send_grad(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        wait_idle();
        exp_cnt++;
        check("t3_cnt_after", upd_count_o, exp_cnt);
        check("t3_err_sticky", 32'(err_o), 1);
        err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
        check("t3_err_clr", 32'(err_o), 0);

        base = n_strobe;
        send_grad(16'h0101, 16'h0202, 16'h0303, 16'h0404);
        n = 0;
        while (!(n_strobe == base + 2 && busy_i) && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        cfg_i = 24'h123456;
        cfg_valid_i = 1'b1;
        exp_cnt++;
        n = 0;
        #1;
        while (!cfg_ready_o && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check("t4_strobes_before_cfg", n_strobe - base, 4);
        check("t4_cnt_before_cfg", upd_count_o, exp_cnt);
        exp_q.push_back(32'h0012_3456);
        @(negedge clk);
        cfg_valid_i = 1'b0;
        wait_idle();

        force dut.upd_count_o = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.upd_count_o;
        @(negedge clk);
        check("t6_preload", upd_count_o, 32'hFFFF_FFFF);
        send_grad(16'h0F0F, 16'h1E1E, 16'h2D2D, 16'h3C3C);
        wait_idle();
        check("t6_wrap", upd_count_o, 0);

        base = n_strobe;
        loads = n_load;
        send_grad(16'h5555, 16'h6666, 16'h7777, 16'h8888);
        n = 0;
        while (n_strobe != base + 3 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("t5_data", data_o, 0);
        check("t5_valid", 32'(valid_o), 0);
        check("t5_busy", 32'(seq_busy_o), 0);
        check("t5_cnt", upd_count_o, 0);
        check("t5_ready", 32'({cfg_ready_o, grad_ready_o}), 0);
        check("t5_dropped", exp_q.size(), 1);
        exp_q.delete();
        repeat (5) @(negedge clk);
        rstn = 1'b1;
        wait_idle();
        check("t5_no_load", n_load - loads, 0);
        check("q_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end expected end of test");
        $fatal(1, "watchdog");
    end

endmodule
